dg0045_rom_host: RTL and testbench
==================================

# dg0045_rom_host

Program-memory responder for the DG0045 4-bit CPU core: it sits on the CPU's instruction-fetch interface and answers each fetch. It captures the 10-bit PC, which the CPU presents five bits at a time under PC_MUX control, and returns the instruction byte on the CPU's ROM input within the same machine cycle. It also owns program loading: it holds the CPU in reset while the ROM is filled through a valid/ready byte stream, then releases it with its 8-phase clock counter aligned to the host's.

## Interface
- DEPTH, 1024: number of ROM bytes, 1..1024; addresses >= DEPTH read as FILL.
- FILL, 8'h00: byte returned for out-of-range fetch addresses.
- clk  in  1  system clock; the same clock as the CPU.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- ena  in  1  global enable; the phase counter advances only when it is 1.
- load_valid  in  1  load byte offered.
- load_ready  out  1  host accepts a load byte.
- load_data  in  8  program byte.
- load_done  in  1  single-cycle pulse: end of load, start the CPU.
- load_start  in  1  single-cycle pulse: abort run, return to LOAD.
- cpu_rst_n  out  1  registered reset to the CPU's rst_n.
- cpu_ena  out  1  to the CPU's ena.
- pc_mux  out  1  to the CPU's PC_MUX (uio_in[5]).
- pc_hl  in  5  from the CPU's PC_HL (uo_out[4:0]).
- rom_data  out  8  to the CPU's mainROM (ui_in).
- fetch_addr  out  10  last fetched PC {PU,PL}.
- fetch_strobe  out  1  one-cycle pulse per completed fetch.

## Operation
- FSM, 2 states:
  - LOAD, entered at reset and on load_start.
  - RUN, entered on load_done while in LOAD.
- LOAD state:
  - cpu_rst_n=0, cpu_ena=0, phase ph held at 0, rom_data=0, pc_mux=0.
  - load_ready = (wptr < DEPTH), combinational.
  - On load_valid && load_ready: mem[wptr] <= load_data, wptr <= wptr+1. wptr is 11 bits.
  - When wptr reaches DEPTH, load_ready=0 and further bytes are ignored (not written, no wrap).
  - On load_done: go to RUN.
    - A byte accepted in the same cycle is still written.
    - Unwritten locations keep their previous contents.
- RUN state:
  - cpu_rst_n=1, cpu_ena=ena, load_ready=0; load_valid and load_done are ignored.
  - ph (3 bits) increments when ena=1 and wraps 7->0. It mirrors the CPU's internal clock divider exactly.
  - pc_mux = (ph==3), combinational from ph. In every other phase pc_mux=0, so pc_hl carries PL[4:0].
  - Edge leaving ph2 (ena=1): lo <= pc_hl, which holds PL[4:0]. The CPU PC has been stable since entering ph2.
  - During ph3:
    - pc_hl carries {PU,PL[5]}.
    - Address A = {pc_hl, lo}, combinational.
    - rom_data = (A < DEPTH) ? mem[A] : FILL, combinational asynchronous read.
  - Edge leaving ph3 (ena=1), which is also the CPU's nowCMD capture edge:
    - fetch_addr <= A.
    - held byte <= rom_data.
    - fetch_strobe <= 1 for exactly one cycle.
  - Outside ph3, rom_data = held byte.
  - On load_start: go to LOAD; wptr <= 0; cpu_rst_n drops at that edge.
- The host does not decode instructions; skips are handled inside the CPU, and the host fetches every cycle.

## Timing
- Reset values:
  - state=LOAD, wptr=0, ph=0, lo=0.
  - cpu_rst_n=0, cpu_ena=0, pc_mux=0, rom_data=0.
  - fetch_addr=0, fetch_strobe=0, load_ready=1 (for DEPTH>=1).
  - ROM array is not reset.
- cpu_rst_n rises at the load_done edge. The CPU divider and ph both leave 0 on the next enabled edge and stay aligned.
- Fetch latency:
  - Address capture to data valid is combinational within ph3.
  - One machine cycle = 8 enabled clocks; exactly one fetch per machine cycle.
  - The first fetch completes on the 4th enabled edge after release.
- ena=0 freezes ph, lo, the held byte and the fetch outputs; cpu_ena follows ena in RUN.
- load_start takes priority over any RUN activity in the same cycle; a fetch in progress is abandoned with no strobe.
- Async reset mid-load or mid-run returns everything to its reset values; the ROM is retained.

## Test plan
- Load 4 bytes A5,3C,81,00 with continuous valid, then load_done -> load_ready=1 throughout, mem[0..3] match; cpu_rst_n=1 on the next cycle.
- Model CPU PC=0x2B5 ({PU=1010, PL=110101}) -> pc_mux=1 only in ph3; fetch_addr=0x2B5 and rom_data=mem[0x2B5] valid before the ph3->ph4 edge; fetch_strobe one cycle.
- DEPTH=16, fetch address 0x3FF -> rom_data=FILL=00.
- DEPTH=4, offer 6 bytes -> only 4 written; load_ready=0 after the 4th byte; load_done still starts the CPU.
- Toggle ena low for 5 cycles during ph3 -> ph, rom_data and the strobe hold; the fetch completes correctly after resume.
- load_start during ph3 -> LOAD next cycle, cpu_rst_n=0, no fetch_strobe, wptr=0; reloading overwrites from address 0.

Source files
------------

// File: rtl/dg0045_rom_host.sv
// Program-memory responder for the DG0045 4-bit CPU core.
// While the CPU is held in reset it fills the ROM from a valid/ready byte stream.
// It then runs an 8-phase counter that stays in lockstep with the CPU clock divider.
// In ph3 it assembles the 10-bit PC and returns the addressed instruction byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | CPU held in reset, ROM accepts bytes from the load stream
// ST_RUN   | CPU released, one instruction fetch per 8 enabled clocks
module dg0045_rom_host #(
    parameter int          DEPTH = 1024,
    parameter logic [7:0]  FILL  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_data,
    input  logic        load_done,
    input  logic        load_start,
    output logic        cpu_rst_n,
    output logic        cpu_ena,
    output logic        pc_mux,
    input  logic [4:0]  pc_hl,
    output logic [7:0]  rom_data,
    output logic [9:0]  fetch_addr,
    output logic        fetch_strobe
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [10:0] wptr_q;
    logic [2:0]  ph_q;
    logic [4:0]  lo_q;
    logic [7:0]  held_q;
    logic        cpu_rst_q;
    logic [7:0]  mem [DEPTH];

    logic [9:0]  addr;
    logic [7:0]  rd_byte;
    logic        accept;
    logic        adv;

    // Fetch address: upper five bits come from pc_hl while pc_mux is high in ph3.
    always_comb begin
        addr    = {pc_hl, lo_q};
        rd_byte = ({1'b0, addr} < DEPTH_W) ? mem[addr[AW-1:0]] : FILL;
    end

    // Next state and CPU-facing outputs; load_start wins over everything else.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        cpu_ena    = 1'b0;
        pc_mux     = 1'b0;
        rom_data   = 8'h00;
        case (state_q)
            ST_LOAD: begin
                load_ready = (wptr_q < DEPTH_W);
                if (!load_start && load_done)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                cpu_ena  = ena;
                pc_mux   = (ph_q == 3'd3);
                rom_data = (ph_q == 3'd3) ? rd_byte : held_q;
                if (load_start)
                    state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Qualified load-write and phase-advance strobes.
    always_comb begin
        accept = (state_q == ST_LOAD) && load_valid && load_ready && !load_start;
        adv    = (state_q == ST_RUN) && ena && !load_start;
    end

    // State, write pointer, phase counter and fetch capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            wptr_q       <= 11'd0;
            ph_q         <= 3'd0;
            lo_q         <= 5'd0;
            held_q       <= 8'h00;
            cpu_rst_q    <= 1'b0;
            fetch_addr   <= 10'd0;
            fetch_strobe <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rst_q    <= (state_d == ST_RUN);
            fetch_strobe <= 1'b0;
            if (load_start) begin
                wptr_q <= 11'd0;
                ph_q   <= 3'd0;
            end else if (state_q == ST_LOAD) begin
                ph_q <= 3'd0;
                if (accept)
                    wptr_q <= wptr_q + 11'd1;
            end else if (adv) begin
                ph_q <= ph_q + 3'd1;
                if (ph_q == 3'd2)
                    lo_q <= pc_hl;
                if (ph_q == 3'd3) begin
                    fetch_addr   <= addr;
                    held_q       <= rd_byte;
                    fetch_strobe <= 1'b1;
                end
            end
        end
    end

    // ROM array write port; the contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr_q[AW-1:0]] <= load_data;
    end

    assign cpu_rst_n = cpu_rst_q;

endmodule

// File: tb/tb_dg0045_rom_host.sv
// Bench for dg0045_rom_host: the bench plays the CPU and the loader.
// A behavioural ROM/phase model is compared against the DUT on every falling edge.
module tb_dg0045_rom_host;

    localparam int         DEPTH = 1000;
    localparam logic [7:0] FILL  = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_done = 1'b0;
    logic       load_start = 1'b0;
    logic [4:0] pc_hl = 5'd0;
    logic       load_ready, cpu_rst_n, cpu_ena, pc_mux, fetch_strobe;
    logic [7:0] rom_data;
    logic [9:0] fetch_addr;

    dg0045_rom_host #(.DEPTH(DEPTH), .FILL(FILL)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_done(load_done), .load_start(load_start),
        .cpu_rst_n(cpu_rst_n), .cpu_ena(cpu_ena), .pc_mux(pc_mux), .pc_hl(pc_hl),
        .rom_data(rom_data), .fetch_addr(fetch_addr), .fetch_strobe(fetch_strobe)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    bit         m_run;
    int         m_ph;
    logic [4:0] m_lo;
    logic [7:0] m_held;
    logic [9:0] m_faddr;
    bit         m_strobe;
    int         m_wptr;
    logic [7:0] mem_m [1024];
    logic [9:0] pc = 10'd0;
    int         force_pc = -1;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    function automatic logic [7:0] rd(input logic [9:0] a);
        return (int'(a) < DEPTH) ? mem_m[a] : FILL;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_ph = 0; m_lo = 5'd0; m_held = 8'h00;
        m_faddr = 10'd0; m_strobe = 1'b0; m_wptr = 0;
    endtask

    function automatic logic [9:0] next_pc();
        if (force_pc >= 0) begin
            next_pc  = force_pc[9:0];
            force_pc = -1;
        end else if ($urandom_range(0, 3) == 0)
            next_pc = 10'($urandom_range(990, 1023));
        else
            next_pc = 10'($urandom_range(0, 1023));
    endfunction

    // Apply the rules of one rising edge to the model using the inputs present at that edge.
    task automatic model_update();
        if (!rst_n) model_reset();
        else if (!m_run) begin
            m_strobe = 1'b0;
            if (load_start) m_wptr = 0;
            else begin
                if (load_valid && m_wptr < DEPTH) begin
                    mem_m[m_wptr] = load_data;
                    m_wptr++;
                end
                if (load_done) begin
                    m_run = 1'b1;
                    m_ph  = 0;
                end
            end
        end else if (load_start) begin
            m_run = 1'b0; m_wptr = 0; m_ph = 0; m_strobe = 1'b0;
        end else if (ena) begin
            m_strobe = 1'b0;
            if (m_ph == 1) pc = next_pc();
            if (m_ph == 2) m_lo = pc[4:0];
            if (m_ph == 3) begin
                m_faddr  = {pc[9:5], m_lo};
                m_held   = rd(m_faddr);
                m_strobe = 1'b1;
            end
            m_ph = (m_ph + 1) % 8;
        end else
            m_strobe = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        pc_hl = (m_run && m_ph == 3) ? pc[9:5] : pc[4:0];
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("load_ready",   10'(load_ready),   10'(!m_run && m_wptr < DEPTH));
            check("cpu_rst_n",    10'(cpu_rst_n),    10'(m_run));
            check("cpu_ena",      10'(cpu_ena),      10'(m_run && ena));
            check("pc_mux",       10'(pc_mux),       10'(m_run && m_ph == 3));
            check("rom_data",     10'(rom_data),
                  10'(!m_run ? 8'h00 : (m_ph == 3 ? rd({pc[9:5], m_lo}) : m_held)));
            check("fetch_addr",   fetch_addr,        m_faddr);
            check("fetch_strobe", 10'(fetch_strobe), 10'(m_strobe));
        end
    end

    logic [7:0] head [4] = '{8'hA5, 8'h3C, 8'h81, 8'h00};
    logic [7:0] rel  [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        model_reset();
        chk_on = 1'b1;
        ena = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_load_ready", 10'(load_ready), 10'd1);
        check("rst_cpu_rst_n",  10'(cpu_rst_n),  10'd0);
        check("rst_rom_data",   10'(rom_data),   10'd0);
        check("rst_fetch_addr", fetch_addr,      10'd0);

        // Full load with two surplus bytes; 0x2B5 gets a known value.
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_valid = 1'b1;
            ena        = 1'($urandom_range(0, 1));
            if (i < 4)            load_data = head[i];
            else if (i == 'h2B5)  load_data = 8'hC3;
            else                  load_data = 8'($urandom);
            tick();
        end
        load_valid = 1'b0;
        @(negedge clk);
        check("full_load_ready", 10'(load_ready), 10'd0);

        // Release with a stray byte offered (ignored, ROM full) and first PC forced.
        force_pc   = 'h2B5;
        ena        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        load_done  = 1'b1;
        tick();
        load_done  = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        check("release_rst_n", 10'(cpu_rst_n), 10'd1);
        repeat (3) tick();
        @(negedge clk);
        check("ph3_pc_mux",   10'(pc_mux),       10'd1);
        check("ph3_rom_data", 10'(rom_data),     10'h0C3);
        check("ph3_strobe",   10'(fetch_strobe), 10'd0);
        tick();
        @(negedge clk);
        check("fetch1_strobe", 10'(fetch_strobe), 10'd1);
        check("fetch1_addr",   fetch_addr,        10'h2B5);
        check("fetch1_held",   10'(rom_data),     10'h0C3);

        // Out-of-range fetch returns FILL.
        force_pc = 'h3FF;
        repeat (7) tick();
        @(negedge clk);
        check("oor_rom_data", 10'(rom_data), 10'h05A);
        tick();
        @(negedge clk);
        check("oor_fetch_addr", fetch_addr, 10'h3FF);

        // Stall five cycles in ph3, then resume.
        repeat (7) tick();
        ena = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("stall_pc_mux", 10'(pc_mux),       10'd1);
        check("stall_strobe", 10'(fetch_strobe), 10'd0);
        ena = 1'b1;
        tick();
        @(negedge clk);
        check("resume_strobe", 10'(fetch_strobe), 10'd1);

        // Randomized traffic, with one asynchronous reset mid-stream.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                tick();
                tick();
                rst_n = 1'b1;
            end
            ena        = ($urandom_range(0, 3) != 0);
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 8'($urandom);
            if (m_run) begin
                load_start = ($urandom_range(0, 249) == 0);
                load_done  = ($urandom_range(0, 7) == 0);
            end else begin
                load_start = 1'b0;
                load_done  = ($urandom_range(0, 11) == 0);
            end
            tick();
        end
        load_start = 1'b0;
        load_done  = 1'b0;
        load_valid = 1'b0;

        // Abort during ph3, then reload three bytes from address 0.
        if (!m_run) begin
            load_done = 1'b1;
            tick();
            load_done = 1'b0;
        end
        ena = 1'b1;
        for (int k = 0; k < 16 && !(m_run && m_ph == 3); k++) tick();
        @(negedge clk);
        check("reach_ph3", 10'(pc_mux), 10'd1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        @(negedge clk);
        check("abort_rst_n",  10'(cpu_rst_n),    10'd0);
        check("abort_strobe", 10'(fetch_strobe), 10'd0);
        check("abort_ready",  10'(load_ready),   10'd1);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = rel[i];
            tick();
        end
        load_valid = 1'b0;
        force_pc   = 'h001;
        load_done  = 1'b1;
        tick();
        load_done  = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("reload_addr", fetch_addr,    10'h001);
        check("reload_data", 10'(rom_data), 10'h022);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
